// File: rtl/sdcard_axil_pkg.sv
// Shared constants, state enums and byte-merge helper for the SD card AXI4-Lite register slave.
package sdcard_axil_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam int NUM_REGS = 4;

  localparam logic [3:0] REG0_OFF = 4'h0;
  localparam logic [3:0] REG1_OFF = 4'h4;
  localparam logic [3:0] REG2_OFF = 4'h8;
  localparam logic [3:0] REG3_OFF = 4'hC;

  typedef enum logic [1:0] {
    W_IDLE,
    W_WAIT_W,
    W_WAIT_AW,
    W_RESP
  } wrState_e;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } rdState_e;

  // Lanes with a clear strobe keep their previous byte.
  function automatic logic [31:0] mergeBytes(input logic [31:0] oldVal,
                                             input logic [31:0] newVal,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    res = oldVal;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) res[8*b +: 8] = newVal[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/sdcard_axil_wr_fsm.sv
// AXI4-Lite write-channel handshake FSM; captures AW and W independently and
// presents a single-cycle commit with the merged address/data to the register array.
module sdcard_axil_wr_fsm
  import sdcard_axil_pkg::*;
#(
  parameter int C_ADDR_WIDTH = 4
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic [C_ADDR_WIDTH-1:0] awaddr_i,
  input  logic                    awvalid_i,
  output logic                    awready_o,
  input  logic [31:0]             wdata_i,
  input  logic [3:0]              wstrb_i,
  input  logic                    wvalid_i,
  output logic                    wready_o,
  output logic [1:0]              bresp_o,
  output logic                    bvalid_o,
  input  logic                    bready_i,
  output logic                    commit_o,
  output logic [1:0]              index_o,
  output logic [31:0]             data_o,
  output logic [3:0]              strb_o,
  output logic                    err_o
);

  wrState_e state_q, state_d;
  logic awReady_q, awReady_d;
  logic wReady_q, wReady_d;
  logic [C_ADDR_WIDTH-1:0] addr_q;
  logic [C_ADDR_WIDTH-1:0] selAddr;
  logic [31:0] data_q;
  logic [3:0] strb_q;
  logic [1:0] bresp_q;
  logic awHs, wHs, addrOor;
  logic unusedAddrBits;

  assign awHs = awvalid_i & awReady_q;
  assign wHs  = wvalid_i & wReady_q;

  // READY flops are loaded from the next state so they stay low through reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= W_IDLE;
      awReady_q <= 1'b0;
      wReady_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      awReady_q <= awReady_d;
      wReady_q  <= wReady_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      addr_q  <= '0;
      data_q  <= '0;
      strb_q  <= '0;
      bresp_q <= RESP_OKAY;
    end else begin
      if (awHs) addr_q <= awaddr_i;
      if (wHs) begin
        data_q <= wdata_i;
        strb_q <= wstrb_i;
      end
      if (commit_o) bresp_q <= err_o ? RESP_SLVERR : RESP_OKAY;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      W_IDLE: begin
        if (awHs && wHs)  state_d = W_RESP;
        else if (awHs)    state_d = W_WAIT_W;
        else if (wHs)     state_d = W_WAIT_AW;
      end
      W_WAIT_W:  if (wHs)      state_d = W_RESP;
      W_WAIT_AW: if (awHs)     state_d = W_RESP;
      W_RESP:    if (bready_i) state_d = W_IDLE;
      default:                 state_d = W_IDLE;
    endcase
    awReady_d = (state_d == W_IDLE) || (state_d == W_WAIT_AW);
    wReady_d  = (state_d == W_IDLE) || (state_d == W_WAIT_W);
  end

  always_comb begin
    commit_o = 1'b0;
    case (state_q)
      W_IDLE:    commit_o = awHs & wHs;
      W_WAIT_W:  commit_o = wHs;
      W_WAIT_AW: commit_o = awHs;
      default:   commit_o = 1'b0;
    endcase
  end

  // Whichever half arrived first comes from the capture flops, the other is live.
  assign selAddr = (state_q == W_WAIT_W)  ? addr_q : awaddr_i;
  assign data_o  = (state_q == W_WAIT_AW) ? data_q : wdata_i;
  assign strb_o  = (state_q == W_WAIT_AW) ? strb_q : wstrb_i;
  assign index_o = selAddr[3:2];
  assign err_o   = addrOor;

  if (C_ADDR_WIDTH > 4) begin : gOor
    assign addrOor = |selAddr[C_ADDR_WIDTH-1:4];
  end else begin : gNoOor
    assign addrOor = 1'b0;
  end

  assign unusedAddrBits = ^selAddr[1:0];

  assign awready_o = awReady_q;
  assign wready_o  = wReady_q;
  assign bvalid_o  = (state_q == W_RESP);
  assign bresp_o   = bresp_q;

endmodule

// File: rtl/sdcard_axil_regs.sv
// AXI4-Lite slave holding four 32-bit control registers for the SD card core,
// with byte-lane writes, SLVERR decode and per-register write strobes.
module sdcard_axil_regs
  import sdcard_axil_pkg::*;
#(
  parameter int C_ADDR_WIDTH = 4,
  parameter int C_DATA_WIDTH = 32
) (
  input  logic                        ACLK,
  input  logic                        ARESET,
  input  logic [C_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
  input  logic [2:0]                  S_AXI_AWPROT,
  input  logic                        S_AXI_AWVALID,
  output logic                        S_AXI_AWREADY,
  input  logic [C_DATA_WIDTH-1:0]     S_AXI_WDATA,
  input  logic [C_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
  input  logic                        S_AXI_WVALID,
  output logic                        S_AXI_WREADY,
  output logic [1:0]                  S_AXI_BRESP,
  output logic                        S_AXI_BVALID,
  input  logic                        S_AXI_BREADY,
  input  logic [C_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
  input  logic [2:0]                  S_AXI_ARPROT,
  input  logic                        S_AXI_ARVALID,
  output logic                        S_AXI_ARREADY,
  output logic [C_DATA_WIDTH-1:0]     S_AXI_RDATA,
  output logic [1:0]                  S_AXI_RRESP,
  output logic                        S_AXI_RVALID,
  input  logic                        S_AXI_RREADY,
  output logic [NUM_REGS*32-1:0]      regs_o,
  output logic [NUM_REGS-1:0]         reg_wr_stb_o
);

  logic [NUM_REGS-1:0][31:0] regs_q, regs_d;
  logic [NUM_REGS-1:0] wrStb_q, wrStb_d;
  logic wrCommit, wrErr;
  logic [1:0] wrIndex;
  logic [31:0] wrData;
  logic [3:0] wrStrb;

  rdState_e rdState_q, rdState_d;
  logic arReady_q, arReady_d;
  logic [31:0] rdata_q, rdRegVal;
  logic [1:0] rresp_q;
  logic arHs, arOor;
  logic unusedSignals;

  sdcard_axil_wr_fsm #(
    .C_ADDR_WIDTH(C_ADDR_WIDTH)
  ) uWrFsm (
    .clk_i     (ACLK),
    .reset_i   (ARESET),
    .awaddr_i  (S_AXI_AWADDR),
    .awvalid_i (S_AXI_AWVALID),
    .awready_o (S_AXI_AWREADY),
    .wdata_i   (S_AXI_WDATA),
    .wstrb_i   (S_AXI_WSTRB),
    .wvalid_i  (S_AXI_WVALID),
    .wready_o  (S_AXI_WREADY),
    .bresp_o   (S_AXI_BRESP),
    .bvalid_o  (S_AXI_BVALID),
    .bready_i  (S_AXI_BREADY),
    .commit_o  (wrCommit),
    .index_o   (wrIndex),
    .data_o    (wrData),
    .strb_o    (wrStrb),
    .err_o     (wrErr)
  );

  always_comb begin
    regs_d  = regs_q;
    wrStb_d = '0;
    if (wrCommit && !wrErr) begin
      regs_d[wrIndex]  = mergeBytes(regs_q[wrIndex], wrData, wrStrb);
      wrStb_d[wrIndex] = 1'b1;
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      regs_q  <= '0;
      wrStb_q <= '0;
    end else begin
      regs_q  <= regs_d;
      wrStb_q <= wrStb_d;
    end
  end

  assign regs_o       = regs_q;
  assign reg_wr_stb_o = wrStb_q;

  assign arHs = S_AXI_ARVALID & arReady_q;

  if (C_ADDR_WIDTH > 4) begin : gArOor
    assign arOor = |S_AXI_ARADDR[C_ADDR_WIDTH-1:4];
  end else begin : gNoArOor
    assign arOor = 1'b0;
  end

  // Reads sample regs_q, so a same-edge write commit is not yet visible.
  always_comb begin
    rdRegVal = '0;
    case ({S_AXI_ARADDR[3:2], 2'b00})
      REG0_OFF: rdRegVal = regs_q[0];
      REG1_OFF: rdRegVal = regs_q[1];
      REG2_OFF: rdRegVal = regs_q[2];
      REG3_OFF: rdRegVal = regs_q[3];
      default:  rdRegVal = '0;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      rdState_q <= R_IDLE;
      arReady_q <= 1'b0;
    end else begin
      rdState_q <= rdState_d;
      arReady_q <= arReady_d;
    end
  end

  always_comb begin
    rdState_d = rdState_q;
    case (rdState_q)
      R_IDLE:  if (arHs)         rdState_d = R_DATA;
      R_DATA:  if (S_AXI_RREADY) rdState_d = R_IDLE;
      default:                   rdState_d = R_IDLE;
    endcase
    arReady_d = (rdState_d == R_IDLE);
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      rdata_q <= '0;
      rresp_q <= RESP_OKAY;
    end else if (arHs) begin
      rdata_q <= arOor ? 32'h0 : rdRegVal;
      rresp_q <= arOor ? RESP_SLVERR : RESP_OKAY;
    end
  end

  assign S_AXI_ARREADY = arReady_q;
  assign S_AXI_RVALID  = (rdState_q == R_DATA);
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = rresp_q;

  assign unusedSignals = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_ARADDR[1:0]};

endmodule

// File: doc/sdcard_axil_regs.md
# sdcard_axil_regs

AXI4-Lite slave register file that terminates the host's AXI4-Lite master port on the SD card IP. It holds four 32-bit read/write control registers at offsets 0x0-0xC and presents them, with per-register write strobes, to the SD card controller core. All AXI response generation, byte-lane merging and address decode live here; the core only sees flat register values.

## Interface
- C_ADDR_WIDTH, 4: AXI address width. Values above 4 enable out-of-range decode.
- C_DATA_WIDTH, 32: AXI data width. Only 32 is supported.
- ACLK  in  1  single clock; all logic is rising-edge.
- ARESET  in  1  synchronous, active-high reset.
- S_AXI_AWADDR  in  C_ADDR_WIDTH  write address.
- S_AXI_AWPROT  in  3  ignored.
- S_AXI_AWVALID / S_AXI_AWREADY  in/out  1  write-address handshake.
- S_AXI_WDATA  in  32  write data.
- S_AXI_WSTRB  in  4  byte enables.
- S_AXI_WVALID / S_AXI_WREADY  in/out  1  write-data handshake.
- S_AXI_BRESP  out  2  OKAY=2'b00, SLVERR=2'b10.
- S_AXI_BVALID / S_AXI_BREADY  out/in  1  write-response handshake.
- S_AXI_ARADDR  in  C_ADDR_WIDTH  read address.
- S_AXI_ARPROT  in  3  ignored.
- S_AXI_ARVALID / S_AXI_ARREADY  in/out  1  read-address handshake.
- S_AXI_RDATA  out  32  read data.
- S_AXI_RRESP  out  2  read response.
- S_AXI_RVALID / S_AXI_RREADY  out/in  1  read-data handshake.
- regs_o  out  128  reg0 in bits [31:0] through reg3 in bits [127:96].
- reg_wr_stb_o  out  4  one-cycle pulse in the cycle after a committed write to register n.

## Operation
- Decode: index = addr[3:2]. addr[1:0] is ignored. Any nonzero addr[C_ADDR_WIDTH-1:4] is out of range.
- Write FSM states:
  - W_IDLE: AWREADY=1 and WREADY=1.
  - W_WAIT_W: AW is captured, AWREADY=0, WREADY=1.
  - W_WAIT_AW: W is captured, WREADY=0, AWREADY=1.
  - W_RESP: AWREADY=0, WREADY=0, BVALID=1.
- Write transitions:
  - From W_IDLE: AW and W together go to W_RESP. AW only goes to W_WAIT_W. W only goes to W_WAIT_AW.
  - From a wait state: completion of the missing handshake goes to W_RESP.
  - From W_RESP: BVALID&BREADY goes to W_IDLE.
- Write commit: happens on the edge that ends the second handshake. Each byte lane b with WSTRB[b]=1 takes WDATA[8b+7:8b]; other lanes keep their value. WSTRB=0 is a legal no-op write and returns OKAY.
- Out-of-range write: no register changes, no strobe, BRESP=SLVERR.
- Read FSM states:
  - R_IDLE: ARREADY=1.
  - R_DATA: RVALID=1, ARREADY=0; RDATA/RRESP held stable until RVALID&RREADY, then back to R_IDLE.
- Out-of-range read: RDATA=0, RRESP=SLVERR.
- Read and write paths are independent and may be active in the same cycle.
- Same-register collision: an AR handshake in the same cycle as a write commit returns the pre-write value.

## Timing
- Reset values: all registers 0; regs_o=0; reg_wr_stb_o=0; BVALID=0, RVALID=0; BRESP=0, RRESP=0, RDATA=0; AWREADY, WREADY, ARREADY=0.
- READY outputs are registered. They rise in the first cycle after ARESET deasserts.
- Write latency: final handshake in cycle N; register, regs_o and BVALID update at edge N+1; reg_wr_stb_o is high in cycle N+1 only.
- Write throughput: at most one write per 2 cycles when BREADY is held high.
- Read latency: AR handshake in cycle N; RVALID and RDATA are valid in cycle N+1.
- Read throughput: at most one read per 2 cycles.
- Reset asserted mid-transaction: outstanding AW/W/AR state is dropped, no B/R response is issued, and registers return to 0 on that edge.

## Structure
- Package sdcard_axil_pkg holds:
  - RESP_OKAY and RESP_SLVERR.
  - NUM_REGS=4.
  - Offsets REG0_OFF through REG3_OFF (0x0, 0x4, 0x8, 0xC).
  - Enums for the write and read FSM states.
- Sub-module sdcard_axil_wr_fsm contains the write handshake FSM plus its address/data capture registers. It outputs commit, index, data, strb and err.
- The read path and register array stay in the top level.

## Test plan
- Sequential writes of 0x1, 0x2, 0x3, 0x4 to 0x0, 0x4, 0x8, 0xC, then reads of the same addresses -> data 0x1 to 0x4 in order, all responses OKAY, regs_o=0x00000004_00000003_00000002_00000001.
- Write 0xAABBCCDD to 0x4 with WSTRB=4'b0101 over an existing 0x11223344 -> read returns 0x11BB33DD; reg_wr_stb_o[1] pulses exactly once.
- WVALID presented 3 cycles before AWVALID, with BREADY held low for 5 cycles -> WREADY drops after the W handshake, BVALID holds OKAY stable until BREADY, and no new AW is accepted meanwhile.
- With C_ADDR_WIDTH=6, write 0xFF to 0x10 and read 0x10 -> BRESP=SLVERR, RRESP=SLVERR, RDATA=0, no register change, no strobe.
- Register 2 holds 0x5; AR to 0x8 in the same cycle as a write commit of 0x9 to 0x8 -> RDATA=0x5; a subsequent read returns 0x9.
- ARESET asserted while in W_WAIT_W and R_DATA -> next cycle BVALID=0, RVALID=0, all regs_o=0; the first post-reset write then completes normally.
